jt12_cen_gen: RTL and testbench

- Parametrised multi-channel clock-enable generator; successor to the fixed FM/SSG/ADPCM prescaler.
- Each of CH channels divides a master clock enable by a runtime-programmable integer.
- Any channel can cascade off the previous channel's tick to build long dividers, e.g. 666k/111k/55k style chains.
- Sits between the chip's master cen and the FM, SSG, ADPCM and timer blocks.

---
 rtl/jt12_cen_gen.sv | 70 +++++++
 tb/tb_jt12_cen_gen.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/jt12_cen_gen.sv
// Multi-channel clock-enable generator: each channel divides the master cen (or the
// previous channel's tick) by a runtime-programmable, period-shadowed divisor.
module jt12_cen_gen #(
    parameter int                 CH      = 4,
    parameter int                 CW      = 5,
    parameter logic [CH*CW-1:0]   DIV_RST = '0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               cen_i,
    input  logic [CH*CW-1:0]   div_n_i,
    input  logic [CH-1:0]      cascade_i,
    input  logic [CH-1:0]      ch_en_i,
    input  logic               sync_i,
    output logic [CH-1:0]      cen_out_o
);

    logic [CW-1:0] cnt_q [CH];
    logic [CW-1:0] cnt_d [CH];
    logic [CW-1:0] lim_q [CH];
    logic [CW-1:0] lim_d [CH];
    logic [CH-1:0] tick;
    logic [CH-1:0] cen_out_q;

    // Ripple the tick chain through a local so cascaded channels see their
    // predecessor's tick in the same cycle and stay phase-aligned.
    always_comb begin
        logic prev_tick;
        logic src;
        prev_tick = 1'b0;
        src       = 1'b0;
        tick      = '0;
        for (int i = 0; i < CH; i++) begin
            cnt_d[i] = cnt_q[i];
            lim_d[i] = lim_q[i];
            src      = (i != 0 && cascade_i[i]) ? prev_tick : cen_i;
            tick[i]  = src & ch_en_i[i] & (cnt_q[i] == '0) & ~sync_i;
            if (sync_i || !ch_en_i[i]) begin
                cnt_d[i] = '0;
                lim_d[i] = div_n_i[i*CW +: CW];
            end else if (src) begin
                // New divisor is only taken at wrap, so a period is never cut short.
                if (cnt_q[i] == lim_q[i]) begin
                    cnt_d[i] = '0;
                    lim_d[i] = div_n_i[i*CW +: CW];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
            prev_tick = tick[i];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < CH; i++) begin
                cnt_q[i] <= '0;
                lim_q[i] <= DIV_RST[i*CW +: CW];
            end
            cen_out_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            lim_q     <= lim_d;
            cen_out_q <= tick;
        end
    end

    assign cen_out_o = cen_out_q;

endmodule

// File: tb/tb_jt12_cen_gen.sv
// Directed bench for jt12_cen_gen: expected cen_out vectors are queued as stimulus is
// driven and popped one clock later for comparison.
module tb_jt12_cen_gen;

    localparam int CH = 4;
    localparam int CW = 5;

    logic               clk = 1'b0;
    logic               rst;
    logic               cen;
    logic               sync;
    logic [CH*CW-1:0]   div_n;
    logic [CH-1:0]      cascade;
    logic [CH-1:0]      ch_en;
    logic [CH-1:0]      cen_out;

    logic [CH-1:0]      exp_q [$];
    int                 n_assert = 0;
    int                 n_fail   = 0;

    jt12_cen_gen #(.CH(CH), .CW(CW)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .cen_i     (cen),
        .div_n_i   (div_n),
        .cascade_i (cascade),
        .ch_en_i   (ch_en),
        .sync_i    (sync),
        .cen_out_o (cen_out)
    );

    always #5 clk = ~clk;

    function automatic logic [CH*CW-1:0] pack(input logic [CW-1:0] d0, input logic [CW-1:0] d1,
                                              input logic [CW-1:0] d2, input logic [CW-1:0] d3);
        return {d3, d2, d1, d0};
    endfunction

    task automatic check(input string tag, input logic [CH-1:0] got, input logic [CH-1:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: cen_out=%b expected=%b", tag, got, exp);
        end
    endtask

    task automatic step(input string tag, input logic [CH-1:0] exp);
        logic [CH-1:0] e;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check(tag, cen_out, e);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; cen = 1'b0; sync = 1'b0; div_n = '0; cascade = '0; ch_en = '0;
        #3;
        check("reset", cen_out, 4'b0000);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // Plain divide by 6 on channel 0; a disabled cycle preloads the divisor.
        div_n = pack(5, 0, 0, 0);
        step("t1_setup", 4'b0000);
        ch_en = 4'b0001; cen = 1'b1;
        for (int k = 0; k < 18; k++)
            step("t1_div6", {3'b000, k % 6 == 0});

        // Cascade chain: 12, 12*6, 12*6*2.
        div_n = pack(11, 5, 1, 0); cascade = 4'b0110; ch_en = 4'b0111;
        cen = 1'b0; sync = 1'b1;
        step("t2_sync", 4'b0000);
        sync = 1'b0; cen = 1'b1;
        for (int k = 0; k < 288; k++)
            step("t2_chain", {1'b0, k % 144 == 0, k % 72 == 0, k % 12 == 0});

        // cen every other cycle, divide by 3 source ticks; sync beats cen.
        cascade = 4'b0000; ch_en = 4'b0001; div_n = pack(2, 0, 0, 0);
        sync = 1'b1; cen = 1'b1;
        step("t3_sync_prio", 4'b0000);
        sync = 1'b0;
        for (int k = 0; k < 24; k++) begin
            cen = (k % 2 == 0);
            step("t3_half_cen", {3'b000, cen && ((k / 2) % 3 == 0)});
        end

        // Divisor change mid-period takes effect only after the current wrap.
        div_n = pack(5, 0, 0, 0); sync = 1'b1; cen = 1'b0;
        step("t4_sync", 4'b0000);
        sync = 1'b0; cen = 1'b1;
        for (int k = 0; k < 16; k++) begin
            if (k == 3) div_n = pack(1, 0, 0, 0);
            step("t4_shadow", {3'b000, k == 0 || (k >= 6 && k % 2 == 0)});
        end

        // sync while cnt=4 with a new divisor: no tick that cycle, tick on next cen.
        div_n = pack(5, 0, 0, 0); sync = 1'b1; cen = 1'b0;
        step("t5_sync", 4'b0000);
        sync = 1'b0; cen = 1'b1;
        for (int k = 0; k < 14; k++) begin
            sync = (k == 4);
            if (k == 4) div_n = pack(2, 0, 0, 0);
            step("t5_sync_mid", {3'b000, k == 0 || (k >= 5 && (k - 5) % 3 == 0)});
        end
        sync = 1'b0;

        // Asynchronous reset while a pulse is on the output.
        div_n = pack(3, 0, 0, 0); sync = 1'b1; cen = 1'b0;
        step("t6_sync", 4'b0000);
        sync = 1'b0; cen = 1'b1;
        step("t6_pulse", 4'b0001);
        rst = 1'b1;
        #1;
        check("t6_async_rst", cen_out, 4'b0000);
        div_n = '0; cen = 1'b0;
        @(posedge clk);
        #1;
        check("t6_in_reset", cen_out, 4'b0000);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            cen = (k != 3);
            step("t6_after_rst", {3'b000, cen});
        end

        // Disabled ch0 stalls cascaded ch1; re-enable ticks on the first source tick.
        cen = 1'b1; cascade = 4'b0010; ch_en = 4'b0010;
        for (int k = 0; k < 6; k++)
            step("t7_disabled", 4'b0000);
        ch_en = 4'b0011;
        for (int k = 0; k < 4; k++)
            step("t7_reenable", 4'b0011);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
